// File: rtl/z80_mmu_ctrl_if.sv
// CPU, context-switch and MMU write-port signals of z80_mmu_ctrl.
// The slave modport is the controller's view; master is its environment.
interface z80_mmu_ctrl_if;
    logic        i_cpu_cs_n;
    logic        i_cpu_wr_n;
    logic [1:0]  i_cpu_addr;
    logic [7:0]  i_cpu_data;
    logic        o_cpu_wait_n;
    logic        i_ctx_req;
    logic [31:0] i_ctx_blocks;
    logic        o_ctx_busy;
    logic        o_ctx_done;
    logic        o_ready;
    logic        o_mmu_cs_n;
    logic        o_mmu_wr_n;
    logic [1:0]  o_mmu_addr;
    logic [7:0]  o_mmu_data;
    logic [7:0]  i_mmu_data;
    logic        o_err;

    modport slave (
        input  i_cpu_cs_n, i_cpu_wr_n, i_cpu_addr, i_cpu_data, i_ctx_req, i_ctx_blocks, i_mmu_data,
        output o_cpu_wait_n, o_ctx_busy, o_ctx_done, o_ready,
        output o_mmu_cs_n, o_mmu_wr_n, o_mmu_addr, o_mmu_data, o_err
    );

    modport master (
        output i_cpu_cs_n, i_cpu_wr_n, i_cpu_addr, i_cpu_data, i_ctx_req, i_ctx_blocks, i_mmu_data,
        input  o_cpu_wait_n, o_ctx_busy, o_ctx_done, o_ready,
        input  o_mmu_cs_n, o_mmu_wr_n, o_mmu_addr, o_mmu_data, o_err
    );
endinterface

// File: rtl/z80_mmu_ctrl.sv
// Boot programmer, context-switch sequencer and CPU arbiter for the z80_mmu page-register port.
// Define Z80_MMU_CTRL_READBACK_EN to verify every sequencer write by reading it back.
module z80_mmu_ctrl #(
    parameter logic [7:0]  INIT_BLOCK0 = 8'h00,
    parameter logic [7:0]  INIT_BLOCK1 = 8'h01,
    parameter logic [7:0]  INIT_BLOCK2 = 8'h02,
    parameter logic [7:0]  INIT_BLOCK3 = 8'h03,
    parameter int unsigned WR_CYCLES   = 2
) (
    input logic           i_clk,
    input logic           i_reset_n,
    z80_mmu_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_SETUP, ST_STROBE, ST_HOLD, ST_VERIFY, ST_FINISH, ST_PASS
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       page_q, page_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      blocks_q, blocks_d;
    logic             ctx_mode_q, ctx_mode_d;
    logic             pending_q, pending_d;
    logic             seq_cs_n_q, seq_cs_n_d;
    logic             seq_wr_n_q, seq_wr_n_d;
    logic [1:0]       seq_addr_q, seq_addr_d;
    logic [7:0]       seq_data_q, seq_data_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             advance, start;
`ifdef Z80_MMU_CTRL_READBACK_EN
    logic             err_q, err_d;
`endif

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= ST_SETUP;
            page_q     <= 2'd0;
            cnt_q      <= '0;
            blocks_q   <= {INIT_BLOCK3, INIT_BLOCK2, INIT_BLOCK1, INIT_BLOCK0};
            ctx_mode_q <= 1'b0;
            pending_q  <= 1'b0;
            seq_cs_n_q <= 1'b1;
            seq_wr_n_q <= 1'b1;
            seq_addr_q <= 2'd0;
            seq_data_q <= 8'h00;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
`ifdef Z80_MMU_CTRL_READBACK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            cnt_q      <= cnt_d;
            blocks_q   <= blocks_d;
            ctx_mode_q <= ctx_mode_d;
            pending_q  <= pending_d;
            seq_cs_n_q <= seq_cs_n_d;
            seq_wr_n_q <= seq_wr_n_d;
            seq_addr_q <= seq_addr_d;
            seq_data_q <= seq_data_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef Z80_MMU_CTRL_READBACK_EN
            err_q      <= err_d;
`endif
        end
    end

    // Next state; port outputs are precomputed from the next state so they are registered
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        cnt_d      = cnt_q;
        blocks_d   = blocks_q;
        ctx_mode_d = ctx_mode_q;
        pending_d  = pending_q;
        advance    = 1'b0;
        start      = 1'b0;
`ifdef Z80_MMU_CTRL_READBACK_EN
        err_d      = err_q;
`endif

        // One-deep request latch; requests arriving while one is pending are absorbed
        if (bus.i_ctx_req) pending_d = 1'b1;

        unique case (state_q)
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = CNT_LAST;
            end
            ST_STROBE: begin
                if (cnt_q == '0) state_d = ST_HOLD;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_HOLD: begin
`ifdef Z80_MMU_CTRL_READBACK_EN
                state_d = ST_VERIFY;
                cnt_d   = CNT_LAST;
`else
                advance = 1'b1;
`endif
            end
`ifdef Z80_MMU_CTRL_READBACK_EN
            ST_VERIFY: begin
                if (cnt_q == '0) begin
                    if (bus.i_mmu_data != seq_data_q) err_d = 1'b1;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            ST_FINISH: begin
                if (pending_q) start   = 1'b1;
                else           state_d = ST_PASS;
            end
            ST_PASS: begin
                // A CPU cycle already in flight finishes before the switch starts
                if ((bus.i_ctx_req || pending_q) && bus.i_cpu_cs_n) start = 1'b1;
            end
            default: state_d = ST_PASS;
        endcase

        if (advance) begin
            if (page_q == 2'd3) begin
                state_d = ST_FINISH;
            end else begin
                state_d = ST_SETUP;
                page_d  = page_q + 2'd1;
            end
        end

        if (start) begin
            state_d    = ST_SETUP;
            page_d     = 2'd0;
            blocks_d   = bus.i_ctx_blocks;
            ctx_mode_d = 1'b1;
            pending_d  = 1'b0;
        end

        seq_cs_n_d = !(state_d == ST_STROBE || state_d == ST_VERIFY);
        seq_wr_n_d = (state_d != ST_STROBE);
        seq_addr_d = page_d;
        seq_data_d = blocks_d[{page_d, 3'b000} +: 8];
        ready_d    = ready_q || (state_d == ST_FINISH);
        busy_d     = !(state_d == ST_FINISH || state_d == ST_PASS);
        done_d     = (state_d == ST_FINISH) && ctx_mode_d;
    end

    logic pass_c;
    assign pass_c = (state_q == ST_PASS);

    // CPU owns the MMU port only in PASS; otherwise a CPU access is stretched with WAIT
    assign bus.o_mmu_cs_n   = pass_c ? bus.i_cpu_cs_n : seq_cs_n_q;
    assign bus.o_mmu_wr_n   = pass_c ? bus.i_cpu_wr_n : seq_wr_n_q;
    assign bus.o_mmu_addr   = pass_c ? bus.i_cpu_addr : seq_addr_q;
    assign bus.o_mmu_data   = pass_c ? bus.i_cpu_data : seq_data_q;
    assign bus.o_cpu_wait_n = pass_c || bus.i_cpu_cs_n;
    assign bus.o_ctx_busy   = busy_q;
    assign bus.o_ctx_done   = done_q;
    assign bus.o_ready      = ready_q;
`ifdef Z80_MMU_CTRL_READBACK_EN
    assign bus.o_err        = err_q;
`else
    assign bus.o_err        = 1'b0;
`endif
endmodule

// File: doc/z80_mmu_ctrl.md
Name: z80_mmu_ctrl

Overview:
Sequencer/arbiter in front of the z80_mmu page-register write port. After reset it programs the four page registers with boot blocks. It then passes Z80 bus cycles through to the MMU, and on request performs an atomic 4-page context switch, stalling the CPU via WAIT while it owns the port. It is the only master that drives the MMU's cs_n/wr_n/addr/data inputs.

Parameters:
INIT_BLOCK0, 8'h00, block loaded into page 0 after reset
INIT_BLOCK1, 8'h01, block loaded into page 1 after reset
INIT_BLOCK2, 8'h02, block loaded into page 2 after reset
INIT_BLOCK3, 8'h03, block loaded into page 3 after reset
WR_CYCLES, 2, cycles cs_n/wr_n held low per sequencer write (legal range 1-15)

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_reset_n  in  1  synchronous, active-low reset
i_cpu_cs_n  in  1  CPU chip select for MMU port
i_cpu_wr_n  in  1  CPU write strobe
i_cpu_addr  in  2  CPU page-register index
i_cpu_data  in  8  CPU write data
o_cpu_wait_n  out  1  low = CPU must extend cycle
i_ctx_req  in  1  start context switch (sampled per cycle)
i_ctx_blocks  in  32  page3..page0 blocks, [7:0]=page 0
o_ctx_busy  out  1  sequencer owns MMU port
o_ctx_done  out  1  one-cycle pulse at end of context switch
o_ready  out  1  boot programming complete
o_mmu_cs_n  out  1  to MMU i_cs_n
o_mmu_wr_n  out  1  to MMU i_wr_n
o_mmu_addr  out  2  to MMU i_addr
o_mmu_data  out  8  to MMU i_data
i_mmu_data  in  8  from MMU o_data (readback)
o_err  out  1  sticky readback mismatch

Behaviour:
- Reset (i_reset_n=0 at a rising edge): state=BOOT_SETUP, page index=0, o_mmu_cs_n=1, o_mmu_wr_n=1, o_mmu_addr=0, o_mmu_data=0, o_cpu_wait_n=1, o_ctx_busy=1, o_ctx_done=0, o_ready=0, o_err=0, pending flag=0.
- Reset mid-sequence aborts immediately and restarts boot programming from page 0.
- States: SETUP -> STROBE -> HOLD -> (next page: SETUP | last page: FINISH) -> PASS.
  - SETUP (1 cycle): addr/data driven; cs_n=wr_n=1.
  - STROBE (WR_CYCLES cycles): cs_n=wr_n=0; addr/data stable.
  - HOLD (1 cycle): cs_n=wr_n=1; addr/data still stable.
  - Source for each page is INIT_BLOCKn (boot) or the latched ctx word (switch).
- Write cost: WR_CYCLES+2 cycles per page; a 4-page sequence takes 4*(WR_CYCLES+2) cycles (16 at default).
- Boot completion: the FINISH cycle sets o_ready=1 (stays 1 until reset) and o_ctx_busy=0. No o_ctx_done pulse for boot.
- PASS: o_mmu_* equal i_cpu_* combinationally; o_cpu_wait_n=1.
- Context switch start:
  - In PASS with i_ctx_req=1 and i_cpu_cs_n=1: latch i_ctx_blocks, go to SETUP page 0, and set o_ctx_busy=1 on the next cycle.
  - If i_cpu_cs_n=0 while i_ctx_req=1: the CPU cycle completes first; the request is held in the pending flag and starts on the first cycle with i_cpu_cs_n=1.
- Context switch end: the FINISH cycle pulses o_ctx_done=1 for exactly 1 cycle and clears o_ctx_busy.
- i_ctx_req while busy: sets the pending flag (one deep; further requests are dropped). Pending starts a new switch immediately after FINISH, using i_ctx_blocks sampled at that start.
- CPU arbitration while busy:
  - i_cpu_cs_n=0 -> o_cpu_wait_n=0 (combinational); the CPU cycle is not forwarded.
  - In PASS after FINISH, wait_n returns to 1 and the held cycle passes through.
  - CPU has priority over a new request only when its cs_n is already low in PASS.
- Page order is always 0,1,2,3; no partial switches.

Optional Feature:
Z80_MMU_CTRL_READBACK_EN.
- Defined:
  - After each HOLD, insert a VERIFY state: cs_n=0, wr_n=1, same addr, for WR_CYCLES cycles.
  - On the last VERIFY cycle compare i_mmu_data with the written byte; a mismatch sets o_err=1 (sticky until reset).
  - The sequence then continues normally. Per-page cost becomes 2*WR_CYCLES+2 cycles.
- Undefined: no VERIFY state; o_err tied 0; i_mmu_data ignored.

Test Plan:
- Boot: release reset with defaults -> MMU page regs 00,01,02,03; o_ready rises exactly 16 cycles after the first cycle with i_reset_n=1; cs_n low 2 cycles per page.
- Context switch: in PASS, pulse i_ctx_req with i_ctx_blocks=32'hDEADBEEF -> pages 0..3 = EF,BE,AD,DE; o_ctx_busy high 16 cycles; o_ctx_done single pulse.
- CPU pass-through: CPU writes 8'h5A to page 2 in PASS -> MMU page 2 = 5A, o_cpu_wait_n stays 1, o_mmu_* mirror CPU same cycle.
- Contention: CPU asserts cs_n during a switch -> o_cpu_wait_n=0 until FINISH; CPU write to page 1 (8'h77) lands after the switch, final page 1 = 77.
- Pending/reset: second i_ctx_req during a switch -> two back-to-back sequences, two done pulses. Assert i_reset_n=0 mid-switch -> outputs to reset values, then boot reprograms 00..03.
- Readback (macro defined): force i_mmu_data mismatch on page 3 -> o_err=1 and stays 1; with the macro undefined o_err=0.
